// File: rtl/id_ex_pipe_pkg.sv
// Shared widths, the ID/EX payload layout and the update-selection encoding
// for the ID/EX pipeline register.
package id_ex_pipe_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned CTRL_W = 16;
   localparam int unsigned REG_AW = 5;
   localparam int unsigned CNT_W  = 16;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   // Everything that crosses from ID into EX, in one bundle
   typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] rs;
      logic [REG_AW-1:0] rt;
      logic [REG_AW-1:0] rd;
      logic [DATA_W-1:0] rs_data;
      logic [DATA_W-1:0] rt_data;
      logic [DATA_W-1:0] imm;
      logic [DATA_W-1:0] pc;
      logic [CTRL_W-1:0] ctrl;
      logic              reg_write;
      logic              mem_read;
   } ex_stage_t;

   // What the register bank does at the next edge, highest priority first
   typedef enum logic [1:0] {
      UPD_FLUSH  = 2'd0,
      UPD_HOLD   = 2'd1,
      UPD_HAZARD = 2'd2,
      UPD_LOAD   = 2'd3
   } upd_e;

   // A bubble kills every side effect; operand fields are left as they were
   function automatic ex_stage_t make_bubble(input ex_stage_t s);
      ex_stage_t b;
      b           = s;
      b.valid     = 1'b0;
      b.rd        = '0;
      b.ctrl      = '0;
      b.reg_write = 1'b0;
      b.mem_read  = 1'b0;
      return b;
   endfunction

endpackage

// File: rtl/id_ex_pipe_load_use_detect.sv
// Flags a load in EX whose destination is a source of the instruction in ID.
module load_use_detect
   import id_ex_pipe_pkg::*;
(
   input  logic              ex_valid,
   input  logic              ex_mem_read,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              id_valid,
   input  logic              id_uses_rs,
   input  logic              id_uses_rt,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   output logic              load_use
);

   logic ex_is_load;
   logic rs_hit;
   logic rt_hit;

   // $zero is never a real producer, so a load targeting it cannot stall
   always_comb begin
      ex_is_load = ex_valid & ex_mem_read & (ex_rd != '0);
      rs_hit     = id_uses_rs & (id_rs == ex_rd);
      rt_hit     = id_uses_rt & (id_rt == ex_rd);
      load_use   = ex_is_load & id_valid & (rs_hit | rt_hit);
   end

endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with load-use bubble insertion, stall request
// towards PC/IF-ID and a saturating load-use bubble counter.
module id_ex_pipe
   import id_ex_pipe_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_uses_rs,
   input  logic              id_uses_rt,
   input  logic [DATA_W-1:0] id_rs_data,
   input  logic [DATA_W-1:0] id_rt_data,
   input  logic [DATA_W-1:0] id_imm,
   input  logic [DATA_W-1:0] id_pc,
   input  logic [CTRL_W-1:0] id_ctrl,
   input  logic              id_reg_write,
   input  logic              id_mem_read,
   input  logic              flush,
   input  logic              hold,
   output logic              ex_valid,
   output logic [REG_AW-1:0] ex_rs,
   output logic [REG_AW-1:0] ex_rt,
   output logic [REG_AW-1:0] ex_rd,
   output logic [DATA_W-1:0] ex_rs_data,
   output logic [DATA_W-1:0] ex_rt_data,
   output logic [DATA_W-1:0] ex_imm,
   output logic [DATA_W-1:0] ex_pc,
   output logic [CTRL_W-1:0] ex_ctrl,
   output logic              ex_reg_write,
   output logic              ex_mem_read,
   output logic              stall_id,
   output logic [CNT_W-1:0]  load_use_cnt
);

   ex_stage_t        ex_q;
   ex_stage_t        ex_d;
   ex_stage_t        id_stage;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             load_use;
   upd_e             upd;

   load_use_detect u_detect (
      .ex_valid    (ex_q.valid),
      .ex_mem_read (ex_q.mem_read),
      .ex_rd       (ex_q.rd),
      .id_valid    (id_valid),
      .id_uses_rs  (id_uses_rs),
      .id_uses_rt  (id_uses_rt),
      .id_rs       (id_rs),
      .id_rt       (id_rt),
      .load_use    (load_use)
   );

   // Gather the ID-side inputs into the payload layout
   always_comb begin
      id_stage           = '0;
      id_stage.valid     = id_valid;
      id_stage.rs        = id_rs;
      id_stage.rt        = id_rt;
      id_stage.rd        = id_rd;
      id_stage.rs_data   = id_rs_data;
      id_stage.rt_data   = id_rt_data;
      id_stage.imm       = id_imm;
      id_stage.pc        = id_pc;
      id_stage.ctrl      = id_ctrl;
      id_stage.reg_write = id_reg_write;
      id_stage.mem_read  = id_mem_read;
   end

   // A taken branch in EX kills ID outright, so it overrides hold and hazard
   always_comb begin
      upd      = UPD_LOAD;
      ex_d     = ex_q;
      cnt_d    = cnt_q;
      stall_id = (load_use | hold) & ~flush;

      if (flush) begin
         upd = UPD_FLUSH;
      end else if (hold) begin
         upd = UPD_HOLD;
      end else if (load_use) begin
         upd = UPD_HAZARD;
      end

      case (upd)
         UPD_FLUSH: begin
            ex_d = make_bubble(ex_q);
         end
         UPD_HOLD: begin
            ex_d = ex_q;
         end
         UPD_HAZARD: begin
            ex_d = make_bubble(ex_q);
            if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            ex_d = id_stage;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_q  <= '0;
         cnt_q <= '0;
      end else begin
         ex_q  <= ex_d;
         cnt_q <= cnt_d;
      end
   end

   // Outputs are straight taps of the register bank
   always_comb begin
      ex_valid     = ex_q.valid;
      ex_rs        = ex_q.rs;
      ex_rt        = ex_q.rt;
      ex_rd        = ex_q.rd;
      ex_rs_data   = ex_q.rs_data;
      ex_rt_data   = ex_q.rt_data;
      ex_imm       = ex_q.imm;
      ex_pc        = ex_q.pc;
      ex_ctrl      = ex_q.ctrl;
      ex_reg_write = ex_q.reg_write;
      ex_mem_read  = ex_q.mem_read;
      load_use_cnt = cnt_q;
   end

endmodule

// File: tb/tb_id_ex_pipe.sv
// Scoreboard bench for id_ex_pipe: the driver queues hand-derived expectations,
// the monitor checks stall_id before each edge and the EX register after it.
module tb_id_ex_pipe;

   typedef struct packed {
      logic        valid;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic        uses_rs;
      logic        uses_rt;
      logic [31:0] rs_data;
      logic [31:0] rt_data;
      logic [31:0] imm;
      logic [31:0] pc;
      logic [15:0] ctrl;
      logic        reg_write;
      logic        mem_read;
   } instr_t;

   localparam int M_LOAD   = 0;
   localparam int M_BUBBLE = 1;
   localparam int M_KEEP   = 2;

   typedef struct {
      int          tag;
      int          mode;
      instr_t      ins;
      logic        stall;
      logic [15:0] cnt;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        id_valid, id_uses_rs, id_uses_rt, id_reg_write, id_mem_read;
   logic [4:0]  id_rs, id_rt, id_rd;
   logic [31:0] id_rs_data, id_rt_data, id_imm, id_pc;
   logic [15:0] id_ctrl;
   logic        flush, hold;
   logic        ex_valid, ex_reg_write, ex_mem_read, stall_id;
   logic [4:0]  ex_rs, ex_rt, ex_rd;
   logic [31:0] ex_rs_data, ex_rt_data, ex_imm, ex_pc;
   logic [15:0] ex_ctrl, load_use_cnt;

   exp_t   q[$];
   instr_t model_ex;
   int     checks = 0;
   int     errors = 0;

   always #5 clk = ~clk;

   id_ex_pipe dut (
      .clk(clk), .rst(rst),
      .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
      .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
      .id_pc(id_pc), .id_ctrl(id_ctrl), .id_reg_write(id_reg_write),
      .id_mem_read(id_mem_read), .flush(flush), .hold(hold),
      .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
      .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
      .ex_pc(ex_pc), .ex_ctrl(ex_ctrl), .ex_reg_write(ex_reg_write),
      .ex_mem_read(ex_mem_read), .stall_id(stall_id), .load_use_cnt(load_use_cnt)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic instr_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                 input logic urs, input logic urt, input logic [31:0] rsd,
                                 input logic [31:0] rtd, input logic [31:0] imm, input logic [31:0] pc,
                                 input logic [15:0] ctrl, input logic rw, input logic mr);
      instr_t i;
      i = '{valid: 1'b1, rs: rs, rt: rt, rd: rd, uses_rs: urs, uses_rt: urt, rs_data: rsd,
            rt_data: rtd, imm: imm, pc: pc, ctrl: ctrl, reg_write: rw, mem_read: mr};
      return i;
   endfunction

   task automatic drive(input instr_t i, input logic fl, input logic hd);
      id_valid = i.valid;   id_rs = i.rs;           id_rt = i.rt;         id_rd = i.rd;
      id_uses_rs = i.uses_rs; id_uses_rt = i.uses_rt;
      id_rs_data = i.rs_data; id_rt_data = i.rt_data; id_imm = i.imm;     id_pc = i.pc;
      id_ctrl = i.ctrl;     id_reg_write = i.reg_write; id_mem_read = i.mem_read;
      flush = fl;           hold = hd;
   endtask

   // One cycle of stimulus plus the expectation for the edge that ends it
   task automatic step(input int tag, input instr_t i, input logic fl, input logic hd,
                       input int mode, input logic exp_stall, input logic [15:0] exp_cnt);
      exp_t e;
      @(negedge clk);
      drive(i, fl, hd);
      #1;
      e.tag = tag; e.mode = mode; e.ins = i; e.stall = exp_stall; e.cnt = exp_cnt;
      q.push_back(e);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() != 0 && n < 50) begin
         @(posedge clk);
         n++;
      end
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d queued expected 0", q.size());
      end
      @(posedge clk); #3;
   endtask

   // Monitor: stall before the edge, EX register and counter after it
   initial begin
      exp_t e;
      forever begin
         @(negedge clk); #2;
         if (q.size() != 0) begin
            e = q.pop_front();
            check($sformatf("v%0d stall_id", e.tag), 64'(stall_id), 64'(e.stall));
            @(posedge clk); #1;
            if (e.mode == M_LOAD) begin
               model_ex = e.ins;
            end else if (e.mode == M_BUBBLE) begin
               model_ex.valid = 1'b0; model_ex.rd = '0; model_ex.ctrl = '0;
               model_ex.reg_write = 1'b0; model_ex.mem_read = 1'b0;
            end
            check($sformatf("v%0d ex_valid", e.tag), 64'(ex_valid), 64'(model_ex.valid));
            check($sformatf("v%0d ex_regs", e.tag), 64'({ex_rs, ex_rt, ex_rd}),
                  64'({model_ex.rs, model_ex.rt, model_ex.rd}));
            check($sformatf("v%0d ex_data", e.tag), {ex_rs_data, ex_rt_data},
                  {model_ex.rs_data, model_ex.rt_data});
            check($sformatf("v%0d ex_imm_pc", e.tag), {ex_imm, ex_pc}, {model_ex.imm, model_ex.pc});
            check($sformatf("v%0d ex_ctrl", e.tag), 64'({ex_ctrl, ex_reg_write, ex_mem_read}),
                  64'({model_ex.ctrl, model_ex.reg_write, model_ex.mem_read}));
            check($sformatf("v%0d load_use_cnt", e.tag), 64'(load_use_cnt), 64'(e.cnt));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      instr_t nop, a, l, d, l0, d0, n, dinv;
      nop  = '0;
      a    = mk(5'd8,  5'd9, 5'd10, 1'b1, 1'b1, 32'h11, 32'h22, 32'h0, 32'h4, 16'h0021, 1'b1, 1'b0);
      l    = mk(5'd29, 5'd8, 5'd8,  1'b1, 1'b0, 32'h1000, 32'h0, 32'h4, 32'h8, 16'h0103, 1'b1, 1'b1);
      d    = mk(5'd8,  5'd9, 5'd11, 1'b1, 1'b1, 32'h33, 32'h44, 32'h0, 32'hC, 16'h0021, 1'b1, 1'b0);
      l0   = mk(5'd29, 5'd0, 5'd0,  1'b1, 1'b0, 32'h2000, 32'h0, 32'h8, 32'h10, 16'h0103, 1'b1, 1'b1);
      d0   = mk(5'd0,  5'd9, 5'd12, 1'b1, 1'b1, 32'h55, 32'h66, 32'h0, 32'h14, 16'h0021, 1'b1, 1'b0);
      n    = mk(5'd3,  5'd8, 5'd13, 1'b1, 1'b0, 32'h77, 32'h88, 32'h9, 32'h18, 16'h0045, 1'b1, 1'b0);
      dinv = d; dinv.valid = 1'b0;
      model_ex = '0;

      rst = 1'b1;
      drive(nop, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      check("reset ex_valid", 64'(ex_valid), 64'd0);
      check("reset load_use_cnt", 64'(load_use_cnt), 64'd0);

      // Pass-through, then load followed by a dependent add
      step(1,  a,  1'b0, 1'b0, M_LOAD,   1'b0, 16'd0);
      step(2,  l,  1'b0, 1'b0, M_LOAD,   1'b0, 16'd0);
      step(3,  d,  1'b0, 1'b0, M_BUBBLE, 1'b1, 16'd1);
      step(4,  d,  1'b0, 1'b0, M_LOAD,   1'b0, 16'd1);
      // No false stalls: load to $zero, and rt matching but unused
      step(5,  l0, 1'b0, 1'b0, M_LOAD,   1'b0, 16'd1);
      step(6,  d0, 1'b0, 1'b0, M_LOAD,   1'b0, 16'd1);
      step(7,  l,  1'b0, 1'b0, M_LOAD,   1'b0, 16'd1);
      step(8,  n,  1'b0, 1'b0, M_LOAD,   1'b0, 16'd1);
      // Flush beats load-use
      step(9,  l,  1'b0, 1'b0, M_LOAD,   1'b0, 16'd1);
      step(10, d,  1'b1, 1'b0, M_BUBBLE, 1'b0, 16'd1);
      // Hold freezes EX for three cycles, then the pending hazard bubbles
      step(11, l,  1'b0, 1'b0, M_LOAD,   1'b0, 16'd1);
      step(12, a,  1'b0, 1'b1, M_KEEP,   1'b1, 16'd1);
      step(13, a,  1'b0, 1'b1, M_KEEP,   1'b1, 16'd1);
      step(14, a,  1'b0, 1'b1, M_KEEP,   1'b1, 16'd1);
      step(15, a,  1'b0, 1'b0, M_BUBBLE, 1'b1, 16'd2);
      step(16, a,  1'b0, 1'b0, M_LOAD,   1'b0, 16'd2);
      // Flush with hold still bubbles; invalid ID never stalls
      step(17, l,  1'b0, 1'b0, M_LOAD,   1'b0, 16'd2);
      step(18, d,  1'b1, 1'b1, M_BUBBLE, 1'b0, 16'd2);
      step(19, l,  1'b0, 1'b0, M_LOAD,   1'b0, 16'd2);
      step(20, dinv, 1'b0, 1'b0, M_LOAD, 1'b0, 16'd2);
      step(21, l,  1'b0, 1'b0, M_LOAD,   1'b0, 16'd2);
      drain();

      // Asynchronous reset in the middle of a stall cycle
      @(negedge clk);
      drive(d, 1'b0, 1'b0);
      #2;
      check("pre-reset stall_id", 64'(stall_id), 64'd1);
      rst = 1'b1;
      #1;
      check("async ex_valid", 64'(ex_valid), 64'd0);
      check("async ex_fields", {ex_rs_data, ex_pc}, 64'd0);
      check("async ex_ctl", 64'({ex_rd, ex_ctrl, ex_mem_read}), 64'd0);
      check("async load_use_cnt", 64'(load_use_cnt), 64'd0);
      check("async stall_id", 64'(stall_id), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      model_ex = '0;

      // Saturation: preload near the top, then keep producing bubbles
      @(negedge clk);
      force dut.cnt_q = 16'hFFFD;
      #1;
      release dut.cnt_q;
      step(30, l, 1'b0, 1'b0, M_LOAD,   1'b0, 16'hFFFD);
      step(31, d, 1'b0, 1'b0, M_BUBBLE, 1'b1, 16'hFFFE);
      step(32, l, 1'b0, 1'b0, M_LOAD,   1'b0, 16'hFFFE);
      step(33, d, 1'b0, 1'b0, M_BUBBLE, 1'b1, 16'hFFFF);
      step(34, l, 1'b0, 1'b0, M_LOAD,   1'b0, 16'hFFFF);
      step(35, d, 1'b0, 1'b0, M_BUBBLE, 1'b1, 16'hFFFF);
      step(36, d, 1'b0, 1'b0, M_LOAD,   1'b0, 16'hFFFF);
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
